// File: rtl/mel_pkg.sv
// mel_pkg: shared constants for the mel filter-bank stage.
//   MEL_NUM_BANDS   number of triangular mel bands
//   MEL_LO / MEL_HI first and last FFT bin of each band (monotonic, overlapping)
//   MEL_WGT_LEN     total number of filter weights stored in the weight ROM
//   mel_state_e     accumulator controller FSM states
package mel_pkg;

  localparam int MEL_NUM_BANDS = 20;

  // Band edges follow triangle points 1,2,3,...,44,52,63: band b spans
  // point b to point b+2, so neighbouring bands share bins.
  localparam logic [5:0] MEL_LO [0:MEL_NUM_BANDS-1] = '{
    6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd10, 6'd12,
    6'd14, 6'd16, 6'd19, 6'd22, 6'd25, 6'd28, 6'd32, 6'd36, 6'd40, 6'd44
  };
  localparam logic [5:0] MEL_HI [0:MEL_NUM_BANDS-1] = '{
    6'd3,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd10, 6'd12, 6'd14, 6'd16,
    6'd19, 6'd22, 6'd25, 6'd28, 6'd32, 6'd36, 6'd40, 6'd44, 6'd52, 6'd63
  };

  // Sum of band widths: one weight per (band, bin) pair.
  function automatic int mel_wgt_len();
    int s;
    s = 0;
    for (int b = 0; b < MEL_NUM_BANDS; b++) begin
      s = s + int'(MEL_HI[b]) - int'(MEL_LO[b]) + 1;
    end
    return s;
  endfunction

  localparam int MEL_WGT_LEN = mel_wgt_len();

  // Last DRAIN count: three drain cycles cover the data and product stages.
  localparam logic [1:0] MEL_DRAIN_LAST = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } mel_state_e;

  // Band-edge lookups guarded against out-of-range band indices.
  function automatic logic [5:0] mel_lo(input logic [4:0] band);
    if (band < 5'(MEL_NUM_BANDS)) mel_lo = MEL_LO[band];
    else                          mel_lo = 6'd0;
  endfunction

  function automatic logic [5:0] mel_hi(input logic [4:0] band);
    if (band < 5'(MEL_NUM_BANDS)) mel_hi = MEL_HI[band];
    else                          mel_hi = 6'd0;
  endfunction

endpackage

// File: rtl/mel_accum_ctrl_mac.sv
// mel_mac: registered multiply followed by an accumulator.
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clear        zero the accumulator (start of a band)
//   i_en           i_data/i_wgt hold a valid pair this cycle
//   i_data, i_wgt  unsigned energy word and filter weight
//   o_acc          running sum of products, zero-extended to ACC_W
module mel_mac #(
  parameter int DATA_W = 16,
  parameter int WGT_W  = 12,
  parameter int ACC_W  = DATA_W + WGT_W + 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic [WGT_W-1:0]  i_wgt,
  output logic [ACC_W-1:0]  o_acc
);

  localparam int PROD_W = DATA_W + WGT_W;

  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] r_prod;
  logic              r_prod_vld;
  logic [ACC_W-1:0]  r_acc;

  // Both operands widened to the full product width so nothing is truncated.
  assign w_prod = {{WGT_W{1'b0}}, i_data} * {{DATA_W{1'b0}}, i_wgt};

  // Product stage: capture data x weight one cycle after they arrive.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_prod_vld <= i_en;
      if (i_en) r_prod <= w_prod;
    end
  end

  // Accumulate stage: clear wins over a pending add.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (r_prod_vld) begin
      r_acc <= r_acc + {{(ACC_W-PROD_W){1'b0}}, r_prod};
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mel_accum_ctrl.sv
// mel_accum_ctrl: walks the mel bands over the FFT-energy bank and emits one
// accumulated energy per band.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_addmel_en       start pulse, honoured only while idle
//   o_fft_rd_addr     energy bank address; i_fft_rd_data returns one cycle later
//   o_wgt_addr        weight ROM address;  i_wgt_data returns one cycle later
//   o_mel_data/o_mel_idx/o_mel_valid  band result, index and strobe
//   o_busy            frame in progress
//   o_done            one-cycle pulse after the last band's strobe
module mel_accum_ctrl import mel_pkg::*; #(
  parameter  int DATA_W    = 16,
  parameter  int WGT_W     = 12,
  parameter  int NUM_BANDS = MEL_NUM_BANDS,
  localparam int ACC_W     = DATA_W + WGT_W + 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_addmel_en,
  output logic [5:0]        o_fft_rd_addr,
  input  logic [DATA_W-1:0] i_fft_rd_data,
  output logic [8:0]        o_wgt_addr,
  input  logic [WGT_W-1:0]  i_wgt_data,
  output logic [ACC_W-1:0]  o_mel_data,
  output logic [4:0]        o_mel_idx,
  output logic              o_mel_valid,
  output logic              o_busy,
  output logic              o_done
);

  mel_state_e       r_state;
  mel_state_e       w_state_next;
  logic [4:0]       r_band;
  logic [5:0]       r_bin;
  logic [8:0]       r_wgt_cnt;
  logic [1:0]       r_drain_cnt;
  logic             r_rd_vld;
  logic [ACC_W-1:0] r_mel_data;
  logic [4:0]       r_mel_idx;
  logic             r_mel_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_last_bin;
  logic             w_last_band;
  logic             w_wgt_at_end;
  logic             w_mac_clear;
  logic [ACC_W-1:0] w_acc;

  assign w_last_bin   = (r_bin == mel_hi(r_band));
  assign w_last_band  = (r_band == 5'(NUM_BANDS - 1));
  assign w_wgt_at_end = (r_wgt_cnt == 9'(MEL_WGT_LEN - 1));
  assign w_mac_clear  = (r_state == ST_LOAD);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_addmel_en) w_state_next = ST_LOAD;
        else             w_state_next = ST_IDLE;
      end
      ST_LOAD: w_state_next = ST_READ;
      ST_READ: begin
        if (w_last_bin) w_state_next = ST_DRAIN;
        else            w_state_next = ST_READ;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == MEL_DRAIN_LAST) w_state_next = ST_OUT;
        else                               w_state_next = ST_DRAIN;
      end
      ST_OUT: begin
        if (w_last_band) w_state_next = ST_DONE;
        else             w_state_next = ST_LOAD;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Band, bin, weight and drain counters. The weight counter doubles as the
  // ROM address: it steps between reads of a band and again on entering the
  // next band's LOAD, so o_wgt_addr always shows the last address issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_band      <= 5'd0;
      r_bin       <= 6'd0;
      r_wgt_cnt   <= 9'd0;
      r_drain_cnt <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_addmel_en) begin
            r_band    <= 5'd0;
            r_wgt_cnt <= 9'd0;
          end
        end
        ST_LOAD: begin
          r_bin       <= mel_lo(r_band);
          r_drain_cnt <= 2'd0;
          if ((r_band != 5'd0) && !w_wgt_at_end) r_wgt_cnt <= r_wgt_cnt + 9'd1;
        end
        ST_READ: begin
          if (!w_last_bin) begin
            r_bin <= r_bin + 6'd1;
            if (!w_wgt_at_end) r_wgt_cnt <= r_wgt_cnt + 9'd1;
          end
        end
        ST_DRAIN: r_drain_cnt <= r_drain_cnt + 2'd1;
        ST_OUT: begin
          if (!w_last_band) r_band <= r_band + 5'd1;
        end
        default: begin
          r_band <= r_band;
        end
      endcase
    end
  end

  // Output registers; r_rd_vld marks the cycle the memories return data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_vld    <= 1'b0;
      r_mel_data  <= '0;
      r_mel_idx   <= 5'd0;
      r_mel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_vld    <= (r_state == ST_READ);
      r_mel_valid <= (r_state == ST_OUT);
      r_done      <= (r_state == ST_DONE);
      // Busy covers the last strobe and drops together with the done pulse.
      r_busy      <= (w_state_next != ST_IDLE);
      if (r_state == ST_OUT) begin
        r_mel_data <= w_acc;
        r_mel_idx  <= r_band;
      end
    end
  end

  mel_mac #(
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_mac_clear),
    .i_en    (r_rd_vld),
    .i_data  (i_fft_rd_data),
    .i_wgt   (i_wgt_data),
    .o_acc   (w_acc)
  );

  assign o_fft_rd_addr = r_bin;
  assign o_wgt_addr    = r_wgt_cnt;
  assign o_mel_data    = r_mel_data;
  assign o_mel_idx     = r_mel_idx;
  assign o_mel_valid   = r_mel_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_mel_accum_ctrl.sv
module tb_mel_accum_ctrl;
  import mel_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [5:0]  fft_addr;
  logic [15:0] fft_data;
  logic [8:0]  wgt_addr;
  logic [11:0] wgt_data;
  logic [33:0] mel_data;
  logic [4:0]  mel_idx;
  logic        mel_valid;
  logic        busy;
  logic        done;

  mel_accum_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_addmel_en   (en),
    .o_fft_rd_addr (fft_addr),
    .i_fft_rd_data (fft_data),
    .o_wgt_addr    (wgt_addr),
    .i_wgt_data    (wgt_data),
    .o_mel_data    (mel_data),
    .o_mel_idx     (mel_idx),
    .o_mel_valid   (mel_valid),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  // Synchronous memory models: data valid one cycle after the address.
  logic [15:0] bank [0:63];
  logic [11:0] rom  [0:511];
  always @(posedge clk) begin
    fft_data <= bank[fft_addr];
    wgt_data <= rom[wgt_addr];
  end

  int     n_cmp = 0;
  int     n_err = 0;
  longint cap_data [$];
  int     cap_idx  [$];
  int     cap_cyc  [$];

  typedef struct {
    int     fmode;
    int     wmode;
    int     band;
    longint exp_data;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Modes: 0 = all ones, 1 = bank=address / rom=2, 2 = max values, 3 = random
  task automatic fill(input int fm, input int wm);
    for (int a = 0; a < 64; a++) begin
      case (fm)
        0:       bank[a] = 16'd1;
        1:       bank[a] = 16'(a);
        2:       bank[a] = 16'hFFFF;
        default: bank[a] = 16'($urandom);
      endcase
    end
    for (int a = 0; a < 512; a++) begin
      case (wm)
        0:       rom[a] = 12'd1;
        1:       rom[a] = 12'd2;
        2:       rom[a] = 12'hFFF;
        default: rom[a] = 12'($urandom);
      endcase
    end
  endtask

  function automatic int band_width(input int b);
    return int'(MEL_HI[b]) - int'(MEL_LO[b]) + 1;
  endfunction

  // Reference: weights are laid out band after band in the ROM.
  function automatic longint model_band(input int b);
    int     off;
    longint s;
    off = 0;
    s   = 0;
    for (int p = 0; p < b; p++) off += band_width(p);
    for (int k = 0; k < band_width(b); k++)
      s += longint'(bank[int'(MEL_LO[b]) + k]) * longint'(rom[off + k]);
    return s;
  endfunction

  function automatic int total_weights();
    int t;
    t = 0;
    for (int b = 0; b < MEL_NUM_BANDS; b++) t += band_width(b);
    return t;
  endfunction

  // One frame: start pulse, capture strobes, then check everything against
  // the model. pulse_band > 0 re-pulses start while that band is in progress.
  task automatic run_frame(input int pulse_band);
    int cyc, done_cyc, n_done, max_w, quiet_bad, exp_cyc;
    cap_data.delete();
    cap_idx.delete();
    cap_cyc.delete();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    check("busy_rise", longint'(busy), 1);
    done_cyc  = -1;
    n_done    = 0;
    quiet_bad = 0;
    max_w     = int'(wgt_addr);
    while ((done_cyc < 0 && cyc < 1500) || (done_cyc >= 0 && cyc < done_cyc + 20)) begin
      @(negedge clk);
      cyc++;
      en = 1'b0;
      if (cyc == 1) begin
        check("rd_addr_first", longint'(fft_addr), 1);
        check("wgt_addr_first", longint'(wgt_addr), 0);
      end
      if (cyc == 2) begin
        check("rd_addr_second", longint'(fft_addr), 2);
        check("wgt_addr_second", longint'(wgt_addr), 1);
      end
      if (int'(wgt_addr) > max_w) max_w = int'(wgt_addr);
      if (mel_valid) begin
        cap_data.push_back(longint'(mel_data));
        cap_idx.push_back(int'(mel_idx));
        cap_cyc.push_back(cyc);
        if (pulse_band > 0 && int'(mel_idx) == pulse_band - 1) en = 1'b1;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check("busy_at_done", longint'(busy), 0);
          check("wgt_addr_final", longint'(wgt_addr), longint'(total_weights() - 1));
        end
      end
      if (done_cyc >= 0 && cyc > done_cyc && (busy || mel_valid)) quiet_bad++;
    end
    check("frame_finished", longint'(done_cyc >= 0), 1);
    check("done_count", longint'(n_done), 1);
    check("strobe_count", longint'(cap_idx.size()), 20);
    check("quiet_after_done", longint'(quiet_bad), 0);
    check("wgt_addr_max", longint'(max_w), longint'(total_weights() - 1));
    exp_cyc = 0;
    for (int b = 0; b < cap_idx.size() && b < 20; b++) begin
      exp_cyc += band_width(b) + 5;
      check($sformatf("band%0d_idx", b), longint'(cap_idx[b]), longint'(b));
      check($sformatf("band%0d_data", b), cap_data[b], model_band(b));
      check($sformatf("band%0d_cycle", b), longint'(cap_cyc[b]), longint'(exp_cyc));
    end
    if (cap_cyc.size() == 20)
      check("done_after_last", longint'(done_cyc), longint'(cap_cyc[19] + 1));
  endtask

  vec_t vecs [8];

  initial begin
    int     seen9;
    int     bad;
    vecs[0] = '{fmode: 0, wmode: 0, band: 0,  exp_data: 64'd3};
    vecs[1] = '{fmode: 0, wmode: 0, band: 19, exp_data: 64'd20};
    vecs[2] = '{fmode: 0, wmode: 0, band: 10, exp_data: 64'd6};
    vecs[3] = '{fmode: 1, wmode: 1, band: 0,  exp_data: 64'd12};
    vecs[4] = '{fmode: 1, wmode: 1, band: 19, exp_data: 64'd2140};
    vecs[5] = '{fmode: 2, wmode: 2, band: 19, exp_data: 64'd5367316500};
    vecs[6] = '{fmode: 2, wmode: 2, band: 0,  exp_data: 64'd805097475};
    vecs[7] = '{fmode: 1, wmode: 0, band: 7,  exp_data: 64'd50};

    rst = 1'b1;
    en  = 1'b0;
    fill(0, 0);
    @(negedge clk);
    check("rst_mel_valid", longint'(mel_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_rd_addr", longint'(fft_addr), 0);
    check("rst_wgt_addr", longint'(wgt_addr), 0);
    check("rst_mel_data", longint'(mel_data), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven patterns with hand-derived expectations.
    for (int i = 0; i < 8; i++) begin
      fill(vecs[i].fmode, vecs[i].wmode);
      run_frame(-1);
      if (cap_data.size() > vecs[i].band)
        check($sformatf("vec%0d_band%0d", i, vecs[i].band), cap_data[vecs[i].band], vecs[i].exp_data);
      else
        check($sformatf("vec%0d_missing", i), longint'(cap_data.size()), longint'(vecs[i].band + 1));
    end

    // Start pulse while band 5 is in progress must be ignored.
    fill(3, 3);
    run_frame(5);

    // Reset in the middle of band 10.
    fill(0, 0);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    seen9 = 0;
    for (int c = 0; c < 1500 && seen9 == 0; c++) begin
      @(negedge clk);
      if (mel_valid && mel_idx == 5'd9) seen9 = 1;
    end
    check("reach_band10", longint'(seen9), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_rd_addr", longint'(fft_addr), 0);
    check("midrst_wgt_addr", longint'(wgt_addr), 0);
    check("midrst_mel_data", longint'(mel_data), 0);
    @(posedge clk);
    #1;
    check("midrst_mel_valid", longint'(mel_valid), 0);
    check("midrst_mel_idx", longint'(mel_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (mel_valid || done || busy) bad++;
    end
    check("silent_after_rst", longint'(bad), 0);
    run_frame(-1);

    // Random contents against the model.
    for (int r = 0; r < 2; r++) begin
      fill(3, 3);
      run_frame(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mel_accum_ctrl.md
Name: mel_accum_ctrl

Overview:
- Mel filter-bank stage directly downstream of the FFT-energy register bank (64 entries, written by control_regffte after the square-root stage).
- On addmel_en, walks NUM_BANDS triangular mel bands in order. For each bin of a band it reads the stored energy and a filter weight, then multiply-accumulates them.
- Emits one accumulated mel energy per band to the log/DCT stage.

Parameters:
- DATA_W, 16, width of one FFT-energy word read from the register bank
- WGT_W, 12, width of one unsigned filter weight from the weight ROM
- NUM_BANDS, 20, number of mel bands; must equal MEL_NUM_BANDS in mel_pkg
- ACC_W, DATA_W+WGT_W+6, accumulator/output width (localparam; no overflow possible for bands of up to 64 bins)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- addmel_en  in  1  start pulse; sampled only in IDLE
- fft_rd_addr  out  6  register-bank read address
- fft_rd_data  in  DATA_W  register-bank read data, valid 1 cycle after address
- wgt_addr  out  9  weight ROM address
- wgt_data  in  WGT_W  weight ROM data, valid 1 cycle after address
- mel_data  out  ACC_W  accumulated band energy
- mel_idx  out  5  band index of mel_data
- mel_valid  out  1  one-cycle strobe qualifying mel_data/mel_idx
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last band's mel_valid

Behaviour:
- Reset, asynchronous and active-high:
  - FSM goes to IDLE.
  - fft_rd_addr=0, wgt_addr=0, mel_data=0, mel_idx=0, mel_valid=0, busy=0, done=0.
  - Accumulator, band counter and weight counter are cleared.
  - Reset mid-operation abandons the frame; no partial mel_valid is emitted.
- FSM states and transitions:
  - IDLE: on addmel_en=1 clear the weight counter and band counter, go to LOAD; busy rises next cycle.
  - LOAD (1 cycle): bin=MEL_LO[band]; clear the accumulator; go to READ.
  - READ (one cycle per bin):
    - drive fft_rd_addr=bin and wgt_addr=weight counter;
    - increment the weight counter;
    - if bin==MEL_HI[band] go to DRAIN, else bin+1.
  - DRAIN (3 cycles): flushes the pipeline.
  - OUT (1 cycle):
    - mel_valid=1, mel_data=accumulator, mel_idx=band;
    - if band==NUM_BANDS-1 go to DONE, else band+1 and go to LOAD.
  - DONE (1 cycle): done=1, busy=0; go to IDLE.
- Datapath pipeline:
  - address issued at T;
  - data and weight arrive at T+1 and are multiplied into a registered product;
  - product is added to the accumulator at T+2;
  - the last add lands before OUT.
  - Per-band latency is (bins+5) cycles. Product is unsigned DATA_W×WGT_W, zero-extended to ACC_W.
- addmel_en outside IDLE is ignored; there is no queuing.
- Single-bin band (LO==HI) is legal: mel_data = data×weight.
- Bin 63 is the last legal address; the bin counter never wraps.
- Weight counter runs 0..MEL_WGT_LEN-1 continuously across bands. A new frame restarts it at 0.

Decomposition:
- mel_pkg holds:
  - MEL_NUM_BANDS=20;
  - MEL_LO[0:19] / MEL_HI[0:19] bin-boundary constant arrays (band 0: 1..3, band 19: 44..63, monotonic, adjacent bands overlap);
  - MEL_WGT_LEN = Σ(HI-LO+1);
  - FSM state enum.
- One sub-module, mel_mac: registered multiplier, accumulator, and clear/enable control.

Test Plan:
1. fft_rd_data ≡ 1, wgt_data ≡ 1, pulse addmel_en:
   - 20 mel_valid strobes, mel_idx 0..19 in order;
   - band 0 mel_data=3, band 19 mel_data=20;
   - done one cycle after the idx-19 strobe; busy low afterwards.
2. Timing check for the same frame: band 0 mel_valid occurs exactly 1+3+3+1 cycles after LOAD entry; final wgt_addr issued = MEL_WGT_LEN-1.
3. Model bank fft_rd_data = address, model ROM wgt_data = 2:
   - band 0 mel_data = 2×(1+2+3) = 12;
   - band 19 = 2×Σ(44..63) = 2140.
4. Max values, fft_rd_data=16'hFFFF and wgt_data=12'hFFF: band 19 = 20×65535×4095 with no truncation in ACC_W.
5. Second addmel_en pulse during band 5 is ignored (one done only); rst asserted during band 10 → all outputs 0 next edge, no further mel_valid, new start restarts at band 0 and wgt_addr 0.
